modbus_crc_stream: RTL and testbench
====================================

// Module: modbus_crc_stream
// PURPOSE
//  Parametrised streaming CRC engine for the Modbus RTU datapath; successor to the fixed TX-frame CRC block.
//  Consumes an arbitrary byte stream over a valid/ready handshake and computes a reflected CRC at 1..8 bits/clk.
//  Emits the final CRC (TX generation) and a residue check flag (RX check) at frame end.
//  Sits between the frame builder/parser and the UART byte layer; shared by the TX and RX paths.
// PARAMETERS
//  CRC_W         16       CRC register width (>=8); data byte XORs into bits [7:0]
//  POLY          16'hA001 reflected polynomial (Modbus CRC-16)
//  INIT          16'hFFFF register value at frame start / after each frame
//  XOROUT        16'h0000 XOR applied to crc_out only
//  RESIDUE       16'h0000 register value indicating a good frame (CRC bytes included)
//  BITS_PER_CLK  1        bits processed per SHIFT cycle; legal 1,2,4,8 (elaboration error otherwise)
//  CNT_W         9        byte counter width
// PORTS
//  clk_in       in   1      system clock
//  rst_n_in     in   1      asynchronous reset, active low
//  frame_start  in   1      pulse: abort any frame, load INIT, clear counters
//  din          in   8      data byte
//  din_valid    in   1      din valid
//  din_ready    out  1      engine can accept a byte this cycle
//  frame_end    in   1      pulse: finalise frame after all accepted bytes
//  crc_out      out  CRC_W  final CRC ^ XOROUT; crc_out[7:0] is transmitted first on the line
//  crc_ok       out  1      final register == RESIDUE
//  crc_done     out  1      one-cycle pulse; crc_out/crc_ok valid from this cycle
//  byte_cnt     out  CNT_W  bytes accepted in current frame (saturates at all-ones)
//  busy         out  1      state==SHIFT or frame_end pending
// BEHAVIOUR
//  Reset: state=IDLE, crc_reg=INIT, din_ready=1, crc_out=0, crc_ok=0, crc_done=0, byte_cnt=0, busy=0, pending=0.
//  States: IDLE (din_ready=1), SHIFT (din_ready=0). N = 8/BITS_PER_CLK.
//  IDLE, din_valid&din_ready: crc_reg[7:0]^=din, byte_cnt++, shift_cnt=0, -> SHIFT.
//  SHIFT: each cycle applies BITS_PER_CLK steps r = r[0] ? (r>>1)^POLY : r>>1; after N cycles -> IDLE.
//  Byte throughput: one byte per N+1 cycles; din_ready reasserts the cycle after the last SHIFT.
//  frame_end in IDLE with no byte accepted: on that edge register crc_out/crc_ok, crc_done=1 next cycle,
//   crc_reg<=INIT, byte_cnt<=0 (done pulse and reinit on the same edge).
//  frame_end in SHIFT, or together with an accepted byte: latch pending; finalise on the edge ending
//   the last SHIFT cycle of that byte; din_ready stays 0 until finalised.
//  frame_end with zero bytes: crc_out=INIT^XOROUT, crc_ok=(INIT==RESIDUE), crc_done pulses.
//  frame_start has priority over everything: state->IDLE, crc_reg=INIT, byte_cnt=0, pending=0,
//   no crc_done; a byte presented the same cycle is NOT accepted; crc_out/crc_ok hold.
//  crc_done is high exactly one cycle; crc_out/crc_ok hold until the next finalise or reset.
//  byte_cnt saturates at 2^CNT_W-1; CRC still computed over every accepted byte.
//  din_valid while din_ready=0: ignored; the source holds din until accepted.
//  Async reset mid-frame: immediate return to reset values; no crc_done.
// TESTING
//  T1 BPC=1: stream 01 03 00 00 00 0A, then frame_end -> crc_out=16'hCDC5, crc_done 1 cycle, byte_cnt=6.
//  T2 BPC=8: stream 01 03 00 00 00 0A C5 CD + frame_end -> crc_ok=1, crc_out=16'h0000; one byte per 2 cycles.
//  T3 BPC=4: 01 03 00 00 00 01 -> crc_out=16'h0A84; corrupt last byte to 00 and append 84 0A -> crc_ok=0.
//  T4 frame_end asserted with the 6th byte of T1 (pending) -> identical 16'hCDC5, done after last SHIFT; BPC=1: 54 cycles.
//  T5 frame_start after 3 bytes, then full T1 frame -> no crc_done from aborted frame, result 16'hCDC5.
//  T6 rst_n_in low during SHIFT -> all outputs at reset values; frame_end with no bytes -> crc_out=16'hFFFF.

Source files
------------

// File: rtl/modbus_crc_stream.sv
// Streaming reflected CRC engine for the Modbus RTU byte path (TX generation and RX residue check).
// Each accepted byte is folded into the register over 8/BITS_PER_CLK SHIFT cycles.
module modbus_crc_stream #(
    parameter int               CRC_W        = 16,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(16'hA001),
    parameter logic [CRC_W-1:0] INIT         = CRC_W'(16'hFFFF),
    parameter logic [CRC_W-1:0] XOROUT       = CRC_W'(16'h0000),
    parameter logic [CRC_W-1:0] RESIDUE      = CRC_W'(16'h0000),
    parameter int               BITS_PER_CLK = 1,
    parameter int               CNT_W        = 9
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             frame_start,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             frame_end,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_ok,
    output logic             crc_done,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             busy,
    output logic             state_dbg
);

    localparam int N    = 8 / BITS_PER_CLK;
    localparam int SC_W = (N > 1) ? $clog2(N) : 1;

    if (!(BITS_PER_CLK == 1 || BITS_PER_CLK == 2 || BITS_PER_CLK == 4 || BITS_PER_CLK == 8)) begin : g_bad_bpc
        $error("modbus_crc_stream: BITS_PER_CLK must be 1, 2, 4 or 8");
    end
    if (CRC_W < 8) begin : g_bad_width
        $error("modbus_crc_stream: CRC_W must be at least 8");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             pending_q, pending_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crc_done_q, crc_done_d;

    logic [CRC_W-1:0] crc_next;
    logic [CRC_W-1:0] fin_val;
    logic             finalise;
    logic             last_shift;

    function automatic logic [CRC_W-1:0] crc_steps(input logic [CRC_W-1:0] r_in);
        logic [CRC_W-1:0] r;
        r = r_in;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Handshake: a byte transfers on a rising edge where din_valid && din_ready; the source
    // holds din stable until then, and din_valid while din_ready is low has no effect.
    assign din_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_SHIFT) || pending_q;
    assign state_dbg  = (state_q == S_SHIFT);
    assign crc_out    = crc_out_q;
    assign crc_ok     = crc_ok_q;
    assign crc_done   = crc_done_q;
    assign byte_cnt   = byte_cnt_q;
    assign crc_next   = crc_steps(crc_q);
    assign last_shift = (shift_cnt_q == SC_W'(N - 1));

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        shift_cnt_d = shift_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        pending_d   = pending_q;
        crc_out_d   = crc_out_q;
        crc_ok_d    = crc_ok_q;
        crc_done_d  = 1'b0;
        finalise    = 1'b0;
        fin_val     = crc_q;

        if (frame_start) begin
            state_d     = S_IDLE;
            crc_d       = INIT;
            shift_cnt_d = '0;
            byte_cnt_d  = '0;
            pending_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (din_valid) begin
                        crc_d       = crc_q ^ CRC_W'(din);
                        byte_cnt_d  = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
                        shift_cnt_d = '0;
                        pending_d   = frame_end;
                        state_d     = S_SHIFT;
                    end else if (frame_end) begin
                        finalise = 1'b1;
                        fin_val  = crc_q;
                    end
                end
                S_SHIFT: begin
                    crc_d       = crc_next;
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                    if (frame_end) begin
                        pending_d = 1'b1;
                    end
                    // A frame_end arriving in the final SHIFT cycle finalises on that same edge.
                    if (last_shift) begin
                        state_d     = S_IDLE;
                        shift_cnt_d = '0;
                        if (pending_q || frame_end) begin
                            finalise = 1'b1;
                            fin_val  = crc_next;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (finalise) begin
            crc_out_d  = fin_val ^ XOROUT;
            crc_ok_d   = (fin_val == RESIDUE);
            crc_done_d = 1'b1;
            crc_d      = INIT;
            byte_cnt_d = '0;
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            crc_q       <= INIT;
            shift_cnt_q <= '0;
            byte_cnt_q  <= '0;
            pending_q   <= 1'b0;
            crc_out_q   <= '0;
            crc_ok_q    <= 1'b0;
            crc_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            shift_cnt_q <= shift_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            pending_q   <= pending_d;
            crc_out_q   <= crc_out_d;
            crc_ok_q    <= crc_ok_d;
            crc_done_q  <= crc_done_d;
        end
    end

endmodule

// File: tb/tb_modbus_crc_stream.sv
// Bench for modbus_crc_stream: three instances (1, 4 and 8 bits/clk) driven by directed Modbus frames,
// checked every cycle against a frame-level model plus hand-computed CRC literals.
module tb_modbus_crc_stream;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs: index 0 -> BPC 1, 1 -> BPC 4, 2 -> BPC 8 ----------------
    logic [7:0]  din        [3];
    logic        din_valid  [3];
    logic        frame_start[3];
    logic        frame_end  [3];
    logic        din_ready  [3];
    logic [15:0] crc_out    [3];
    logic        crc_ok     [3];
    logic        crc_done   [3];
    logic [8:0]  byte_cnt   [3];
    logic        busy       [3];
    logic        state_dbg  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        modbus_crc_stream #(.BITS_PER_CLK(BPC)) u_dut (
            .clk_in     (clk),
            .rst_n_in   (rst_n),
            .frame_start(frame_start[g]),
            .din        (din[g]),
            .din_valid  (din_valid[g]),
            .din_ready  (din_ready[g]),
            .frame_end  (frame_end[g]),
            .crc_out    (crc_out[g]),
            .crc_ok     (crc_ok[g]),
            .crc_done   (crc_done[g]),
            .byte_cnt   (byte_cnt[g]),
            .busy       (busy[g]),
            .state_dbg  (state_dbg[g])
        );
    end

    // ---------------- scoreboard counters ----------------
    int n_vec;
    int n_fail;
    int acc_first;
    int acc_last;
    int done_cyc;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic int cycles_per_byte(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
    endfunction

    int          m_shift[3];   // SHIFT cycles still owed for the current byte
    logic        m_pend [3];
    int          m_cnt  [3];
    logic [15:0] m_run  [3];
    logic [15:0] m_out  [3];
    logic        m_ok   [3];
    logic        m_done [3];

    always @(posedge clk or negedge rst_n) begin
        int          sh;
        int          cnt;
        logic        pd;
        logic        fin;
        logic [15:0] run;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_shift[d] <= 0;
                m_pend[d]  <= 1'b0;
                m_cnt[d]   <= 0;
                m_run[d]   <= 16'hFFFF;
                m_out[d]   <= 16'h0000;
                m_ok[d]    <= 1'b0;
                m_done[d]  <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                sh  = m_shift[d];
                pd  = m_pend[d];
                cnt = m_cnt[d];
                run = m_run[d];
                fin = 1'b0;
                if (frame_start[d]) begin
                    sh  = 0;
                    pd  = 1'b0;
                    cnt = 0;
                    run = 16'hFFFF;
                end else if (sh != 0) begin
                    if (frame_end[d]) pd = 1'b1;
                    sh = sh - 1;
                    if (sh == 0 && pd) fin = 1'b1;
                end else if (din_valid[d]) begin
                    run = crc_byte(run, din[d]);
                    cnt = cnt + 1;
                    sh  = cycles_per_byte(d);
                    pd  = frame_end[d];
                end else if (frame_end[d]) begin
                    fin = 1'b1;
                end
                m_done[d] <= fin;
                if (fin) begin
                    m_out[d] <= run;
                    m_ok[d]  <= (run == 16'h0000);
                    run = 16'hFFFF;
                    cnt = 0;
                    pd  = 1'b0;
                end
                m_shift[d] <= sh;
                m_pend[d]  <= pd;
                m_cnt[d]   <= cnt;
                m_run[d]   <= run;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            check("din_ready", d, 32'(din_ready[d]), 32'(m_shift[d] == 0));
            check("busy", d, 32'(busy[d]), 32'((m_shift[d] != 0) || m_pend[d]));
            check("byte_cnt", d, 32'(byte_cnt[d]), (m_cnt[d] > 511) ? 32'd511 : 32'(m_cnt[d]));
            check("crc_done", d, 32'(crc_done[d]), 32'(m_done[d]));
            check("crc_out", d, 32'(crc_out[d]), 32'(m_out[d]));
            check("crc_ok", d, 32'(crc_ok[d]), 32'(m_ok[d]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        @(negedge clk);
        while (!din_ready[d] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!din_ready[d]) begin
            n_vec++;
            n_fail++;
            $display("FAIL idle_timeout dut%0d: din_ready low after %0d cycles, required high", d, k);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_byte(input int d, input logic [7:0] b, input logic fe);
        din[d]       = b;
        din_valid[d] = 1'b1;
        wait_idle(d);
        frame_end[d] = fe;
        sync_edge();
        acc_last     = cyc;
        din_valid[d] = 1'b0;
        frame_end[d] = 1'b0;
    endtask

    task automatic send_vec(input int d, input logic [63:0] v, input int n, input logic fe_last);
        for (int i = 0; i < n; i++) begin
            send_byte(d, v[8*(n-1-i) +: 8], (i == n - 1) ? fe_last : 1'b0);
            if (i == 0) acc_first = acc_last;
        end
    endtask

    task automatic pulse_end(input int d);
        frame_end[d] = 1'b1;
        sync_edge();
        frame_end[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        frame_start[d] = 1'b1;
        sync_edge();
        frame_start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input string name, input logic chk_out, input logic [15:0] exp_out,
                             input logic chk_ok, input logic exp_ok);
        int   k;
        logic seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            if (crc_done[d]) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_done_timeout dut%0d: no crc_done within %0d cycles, required a pulse", name, d, k);
        end else begin
            if (chk_out) check({name, "_crc_out"}, d, 32'(crc_out[d]), 32'(exp_out));
            if (chk_ok) check({name, "_crc_ok"}, d, 32'(crc_ok[d]), 32'(exp_ok));
        end
        done_cyc = cyc;
        sync_edge();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] r;
        n_vec = 0;
        n_fail = 0;
        for (int d = 0; d < 3; d++) begin
            din[d]         = 8'h00;
            din_valid[d]   = 1'b0;
            frame_start[d] = 1'b0;
            frame_end[d]   = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_din_ready", 0, 32'(din_ready[0]), 32'd1);
        check("reset_crc_out", 0, 32'(crc_out[0]), 32'd0);
        check("reset_byte_cnt", 0, 32'(byte_cnt[0]), 32'd0);
        sync_edge();
        rst_n = 1'b1;

        // model pins against published Modbus CRCs
        r = 16'hFFFF;
        r = crc_byte(r, 8'h01); r = crc_byte(r, 8'h03); r = crc_byte(r, 8'h00);
        r = crc_byte(r, 8'h00); r = crc_byte(r, 8'h00); r = crc_byte(r, 8'h0A);
        check("model_pin_t1", 0, 32'(r), 32'hCDC5);
        r = 16'hFFFF;
        r = crc_byte(r, 8'h01); r = crc_byte(r, 8'h03); r = crc_byte(r, 8'h00);
        r = crc_byte(r, 8'h00); r = crc_byte(r, 8'h00); r = crc_byte(r, 8'h01);
        check("model_pin_t3", 1, 32'(r), 32'h0A84);
        sync_edge();

        // T1: BPC=1, frame_end in IDLE
        send_vec(0, 64'h01030000000A, 6, 1'b0);
        wait_idle(0);
        check("t1_byte_cnt", 0, 32'(byte_cnt[0]), 32'd6);
        pulse_end(0);
        wait_done(0, "t1", 1'b1, 16'hCDC5, 1'b1, 1'b0);

        // T4: frame_end together with the last byte
        send_vec(0, 64'h01030000000A, 6, 1'b1);
        wait_done(0, "t4", 1'b1, 16'hCDC5, 1'b1, 1'b0);
        check("t4_cycles", 0, 32'(done_cyc - acc_first + 1), 32'd54);

        // T2: BPC=8, full frame with CRC, frame_end during SHIFT
        send_vec(2, 64'h01030000000AC5CD, 8, 1'b0);
        check("t2_rate", 2, 32'(acc_last - acc_first), 32'd14);
        pulse_end(2);
        wait_done(2, "t2", 1'b1, 16'h0000, 1'b1, 1'b1);

        // T3: BPC=4 generation, good check, corrupted check
        send_vec(1, 64'h010300000001, 6, 1'b0);
        wait_idle(1);
        pulse_end(1);
        wait_done(1, "t3_gen", 1'b1, 16'h0A84, 1'b1, 1'b0);
        send_vec(1, 64'h010300000001840A, 8, 1'b1);
        wait_done(1, "t3_good", 1'b1, 16'h0000, 1'b1, 1'b1);
        send_vec(1, 64'h010300000000840A, 8, 1'b0);
        pulse_end(1);
        wait_done(1, "t3_bad", 1'b0, 16'h0000, 1'b1, 1'b0);

        // T5: abort mid-SHIFT, then frame_start racing a byte, then a clean frame
        send_vec(0, 64'h010300, 3, 1'b0);
        pulse_start(0);
        wait_idle(0);
        check("t5_abort_cnt", 0, 32'(byte_cnt[0]), 32'd0);
        din[0]         = 8'h55;
        din_valid[0]   = 1'b1;
        frame_start[0] = 1'b1;
        sync_edge();
        din_valid[0]   = 1'b0;
        frame_start[0] = 1'b0;
        @(negedge clk);
        check("t5_start_blocks_byte", 0, 32'(byte_cnt[0]), 32'd0);
        sync_edge();
        send_vec(0, 64'h01030000000A, 6, 1'b0);
        pulse_end(0);
        wait_done(0, "t5", 1'b1, 16'hCDC5, 1'b1, 1'b0);

        // byte_cnt saturation, CRC over all bytes (model-checked)
        for (int i = 0; i < 515; i++) send_byte(2, 8'(i), 1'b0);
        wait_idle(2);
        check("sat_byte_cnt", 2, 32'(byte_cnt[2]), 32'd511);
        pulse_end(2);
        wait_done(2, "sat", 1'b0, 16'h0000, 1'b0, 1'b0);

        // T6: async reset during SHIFT, then empty frame
        send_vec(0, 64'h0103, 2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_din_ready", 0, 32'(din_ready[0]), 32'd1);
        check("t6_busy", 0, 32'(busy[0]), 32'd0);
        check("t6_byte_cnt", 0, 32'(byte_cnt[0]), 32'd0);
        check("t6_crc_out", 0, 32'(crc_out[0]), 32'd0);
        check("t6_crc_ok", 0, 32'(crc_ok[0]), 32'd0);
        check("t6_crc_done", 0, 32'(crc_done[0]), 32'd0);
        sync_edge();
        rst_n = 1'b1;
        sync_edge();
        pulse_end(0);
        wait_done(0, "t6_empty", 1'b1, 16'hFFFF, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
